flash_sample_feeder: RTL and testbench

//  Upstream stage of the PicoBlaze audio/LED display. Fetches 32-bit words from

---
 rtl/flash_sample_feeder.sv | 216 +++++++++++++++++++++
 tb/tb_flash_sample_feeder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_sample_feeder.sv
// flash_sample_feeder: fetches 32-bit words (two signed 16-bit samples) from flash
// over an Avalon-MM read master and presents one 8-bit sample per sample-rate tick
// on input_data, pulsing new_value_read for one cycle.
// Optional build macro FLASH_SAMPLE_ABS_EN: output magnitude |s|[15:8], saturated to 0x7F.
module flash_sample_feeder #(
  parameter int CLK_FREQ_HZ    = 25000000,
  parameter int SAMPLE_RATE_HZ = 22000,
  parameter int ADDR_WIDTH     = 23,
  parameter int START_ADDR     = 0,
  parameter int END_ADDR       = 32'h0007_FFFF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  play_enable,
  output logic                  flash_read,
  output logic [ADDR_WIDTH-1:0] flash_address,
  input  logic                  flash_waitrequest,
  input  logic [31:0]           flash_readdata,
  input  logic                  flash_readdatavalid,
  output logic [7:0]            input_data,
  output logic                  new_value_read,
  output logic                  sample_overrun
);

  localparam int DIV   = CLK_FREQ_HZ / SAMPLE_RATE_HZ;
  localparam int DIV_W = $clog2(DIV);
  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [ADDR_WIDTH-1:0] START_A  = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] END_A    = ADDR_WIDTH'(END_ADDR);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_EMIT = 2'd3
  } state_t;

`ifdef FLASH_SAMPLE_ABS_EN
  // Magnitude in 17 bits so that -32768 does not wrap; anything >= 0x8000 clamps to 0x7F.
  function automatic logic [7:0] sample_map(input logic [15:0] s);
    logic [16:0] mag;
    if (s[15]) begin
      mag = 17'd0 - {s[15], s};
    end else begin
      mag = {1'b0, s};
    end
    if (|mag[16:15]) begin
      sample_map = 8'h7F;
    end else begin
      sample_map = mag[15:8];
    end
  endfunction
`else
  // Signed output is simply the top byte of the sample.
  function automatic logic [7:0] sample_map(input logic [7:0] s_hi);
    sample_map = s_hi;
  endfunction
`endif

  state_t                  state_r, state_nx_s;
  logic [DIV_W-1:0]        div_cnt_r;
  logic                    tick_s;
  logic                    word_valid_r;   // high half still to be played
  logic                    lo_pend_r;      // low half held back because play was paused
  logic [7:0]              lo_byte_r, hi_byte_r;
  logic                    flash_read_r;
  logic [ADDR_WIDTH-1:0]   flash_address_r;
  logic [7:0]              input_data_r;
  logic                    new_value_read_r;
  logic                    sample_overrun_r;
  logic                    accept_s, capture_s, emit_s;
  logic [7:0]              emit_byte_s;
  logic                    set_word_s, clr_word_s, set_lo_pend_s, clr_lo_pend_s;
  logic [7:0]              lo_map_s, hi_map_s;

`ifdef FLASH_SAMPLE_ABS_EN
  assign lo_map_s = sample_map(flash_readdata[15:0]);
  assign hi_map_s = sample_map(flash_readdata[31:16]);
`else
  logic unused_readdata_s;
  assign lo_map_s = sample_map(flash_readdata[15:8]);
  assign hi_map_s = sample_map(flash_readdata[31:24]);
  assign unused_readdata_s = ^{flash_readdata[23:16], flash_readdata[7:0]};
`endif

  assign tick_s = play_enable && (div_cnt_r == DIV_LAST);

  // Sample-rate divider: counts while playing, cleared immediately when paused.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_r <= '0;
    end else if (!play_enable || tick_s) begin
      div_cnt_r <= '0;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    state_nx_s    = state_r;
    accept_s      = 1'b0;
    capture_s     = 1'b0;
    emit_s        = 1'b0;
    emit_byte_s   = 8'h00;
    set_word_s    = 1'b0;
    clr_word_s    = 1'b0;
    set_lo_pend_s = 1'b0;
    clr_lo_pend_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tick_s) begin
          if (lo_pend_r) begin
            emit_s        = 1'b1;
            emit_byte_s   = lo_byte_r;
            clr_lo_pend_s = 1'b1;
          end else if (word_valid_r) begin
            emit_s      = 1'b1;
            emit_byte_s = hi_byte_r;
            clr_word_s  = 1'b1;
          end else begin
            state_nx_s = ST_REQ;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (!flash_waitrequest) begin
          accept_s   = 1'b1;
          state_nx_s = ST_WAIT;
        end else begin
          state_nx_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (flash_readdatavalid) begin
          capture_s  = 1'b1;
          state_nx_s = ST_EMIT;
        end else begin
          state_nx_s = ST_WAIT;
        end
      end
      ST_EMIT: begin
        state_nx_s = ST_IDLE;
        set_word_s = 1'b1;
        if (play_enable) begin
          emit_s      = 1'b1;
          emit_byte_s = lo_byte_r;
        end else begin
          set_lo_pend_s = 1'b1;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs: bus request, buffered samples, emission, overrun flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flash_read_r     <= 1'b0;
      flash_address_r  <= START_A;
      word_valid_r     <= 1'b0;
      lo_pend_r        <= 1'b0;
      lo_byte_r        <= 8'h00;
      hi_byte_r        <= 8'h00;
      input_data_r     <= 8'h00;
      new_value_read_r <= 1'b0;
      sample_overrun_r <= 1'b0;
    end else begin
      flash_read_r     <= (state_nx_s == ST_REQ);
      new_value_read_r <= emit_s;
      if (accept_s) begin
        flash_address_r <= (flash_address_r == END_A) ? START_A : flash_address_r + ADDR_WIDTH'(1);
      end
      if (capture_s) begin
        lo_byte_r <= lo_map_s;
        hi_byte_r <= hi_map_s;
      end
      if (emit_s) begin
        input_data_r <= emit_byte_s;
      end
      if (set_word_s) begin
        word_valid_r <= 1'b1;
      end else if (clr_word_s) begin
        word_valid_r <= 1'b0;
      end
      if (set_lo_pend_s) begin
        lo_pend_r <= 1'b1;
      end else if (clr_lo_pend_s) begin
        lo_pend_r <= 1'b0;
      end
      if (tick_s && (state_r != ST_IDLE)) begin
        sample_overrun_r <= 1'b1;
      end
    end
  end

  assign flash_read     = flash_read_r;
  assign flash_address  = flash_address_r;
  assign input_data     = input_data_r;
  assign new_value_read = new_value_read_r;
  assign sample_overrun = sample_overrun_r;

endmodule

// File: tb/tb_flash_sample_feeder.sv
// Self-checking bench for flash_sample_feeder (DIV=10, region words 4..5).
// A behavioural Avalon slave with configurable waitstates/read latency runs alongside.
module tb_flash_sample_feeder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        play_enable;
  logic        flash_read;
  logic [22:0] flash_address;
  logic        flash_waitrequest;
  logic [31:0] flash_readdata;
  logic        flash_readdatavalid;
  logic [7:0]  input_data;
  logic        new_value_read;
  logic        sample_overrun;

  flash_sample_feeder #(
    .CLK_FREQ_HZ(1000), .SAMPLE_RATE_HZ(100), .ADDR_WIDTH(23),
    .START_ADDR(4), .END_ADDR(5)
  ) dut (
    .clk(clk), .reset_n(reset_n), .play_enable(play_enable),
    .flash_read(flash_read), .flash_address(flash_address),
    .flash_waitrequest(flash_waitrequest), .flash_readdata(flash_readdata),
    .flash_readdatavalid(flash_readdatavalid), .input_data(input_data),
    .new_value_read(new_value_read), .sample_overrun(sample_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [7:0] data; } pulse_t;
  typedef struct { logic [31:0] word; int ws; int lat; logic [7:0] exp_lo; logic [7:0] exp_hi; } vec_t;

  pulse_t      pulse_q[$];
  logic [22:0] acc_q[$];
  int          len_q[$];
  bit          addr_moved;
  int          ws_cfg, lat_cfg;
  logic [31:0] word_cfg;
  int          tests = 0;
  int          failed = 0;

  // Slave model and pulse monitor, acting just after each falling edge.
  initial begin
    bit prev_read, prev_wait, lat_active;
    logic [22:0] prev_addr;
    int lat_left, len_cnt;
    prev_read = 0; prev_wait = 0; lat_active = 0; prev_addr = '0;
    lat_left = 0; len_cnt = 0;
    flash_waitrequest = 1'b0; flash_readdatavalid = 1'b0; flash_readdata = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (new_value_read) pulse_q.push_back('{cyc, input_data});
      if (prev_read && !prev_wait) begin
        acc_q.push_back(prev_addr);
        len_q.push_back(len_cnt);
        lat_left = lat_cfg;
        lat_active = 1;
      end
      flash_readdatavalid = 1'b0;
      if (lat_active) begin
        if (lat_left == 0) begin
          flash_readdatavalid = 1'b1;
          flash_readdata = word_cfg;
          lat_active = 0;
        end else begin
          lat_left--;
        end
      end
      if (flash_read) begin
        if (len_cnt > 0 && flash_address != prev_addr) addr_moved = 1;
        flash_waitrequest = (len_cnt < ws_cfg);
        len_cnt++;
      end else begin
        flash_waitrequest = 1'b0;
        len_cnt = 0;
      end
      prev_read = flash_read;
      prev_wait = flash_waitrequest;
      prev_addr = flash_address;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    play_enable = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    pulse_q.delete(); acc_q.delete(); len_q.delete();
    addr_moved = 0;
    @(negedge clk);
  endtask

  initial begin
    vec_t vecs[5];
    int p, q;
    bit found;
`ifdef FLASH_SAMPLE_ABS_EN
    vecs[0] = '{32'hC000_1234, 0, 0, 8'h12, 8'h40};
    vecs[1] = '{32'h8000_FF00, 1, 0, 8'h01, 8'h7F};
    vecs[2] = '{32'h7FFF_0080, 0, 2, 8'h00, 8'h7F};
    vecs[3] = '{32'hFFFF_8001, 2, 1, 8'h7F, 8'h00};
    vecs[4] = '{32'h0100_5A5A, 3, 3, 8'h5A, 8'h01};
`else
    vecs[0] = '{32'hC000_1234, 0, 0, 8'h12, 8'hC0};
    vecs[1] = '{32'h8000_FF00, 1, 0, 8'hFF, 8'h80};
    vecs[2] = '{32'h7FFF_0080, 0, 2, 8'h00, 8'h7F};
    vecs[3] = '{32'hFFFF_8001, 2, 1, 8'h80, 8'hFF};
    vecs[4] = '{32'h0100_5A5A, 3, 3, 8'h5A, 8'h01};
`endif
    reset_n = 1'b0; play_enable = 1'b0;
    ws_cfg = 0; lat_cfg = 0; word_cfg = 32'h0; addr_moved = 0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst flash_read", flash_read, 0);
    check("rst address", flash_address, 4);
    check("rst input_data", input_data, 0);
    check("rst new_value_read", new_value_read, 0);
    check("rst overrun", sample_overrun, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset while a request is stalled
    ws_cfg = 100;
    play_enable = 1'b1; p = cyc;
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (flash_read) found = 1;
    end
    check("t1 request seen", found, 1);
    check("t1 request cycle", cyc, p + 10);
    reset_n = 1'b0;
    #1;
    check("t1 async read drop", flash_read, 0);
    check("t1 address", flash_address, 4);
    check("t1 input_data", input_data, 0);
    check("t1 overrun", sample_overrun, 0);
    ws_cfg = 0;
    do_reset();

    // Table: one word per vector, check both halves, timing and address
    foreach (vecs[i]) begin
      do_reset();
      ws_cfg = vecs[i].ws; lat_cfg = vecs[i].lat; word_cfg = vecs[i].word;
      play_enable = 1'b1; p = cyc;
      wait_until(p + 25);
      play_enable = 1'b0;
      check($sformatf("v%0d pulses", i), pulse_q.size(), 2);
      if (pulse_q.size() >= 2) begin
        check($sformatf("v%0d lo data", i), pulse_q[0].data, vecs[i].exp_lo);
        check($sformatf("v%0d lo cycle", i), pulse_q[0].cyc, p + 13 + vecs[i].ws + vecs[i].lat);
        check($sformatf("v%0d hi data", i), pulse_q[1].data, vecs[i].exp_hi);
        check($sformatf("v%0d hi cycle", i), pulse_q[1].cyc, p + 20);
      end
      check($sformatf("v%0d hold", i), input_data, vecs[i].exp_hi);
      check($sformatf("v%0d overrun", i), sample_overrun, 0);
      check($sformatf("v%0d accepts", i), acc_q.size(), 1);
      if (acc_q.size() >= 1) check($sformatf("v%0d addr", i), acc_q[0], 4);
    end

    // Waitstates: request held 4 cycles, addresses 4 -> 5 -> 4
    do_reset();
    ws_cfg = 3; lat_cfg = 0; word_cfg = 32'h1111_2222;
    play_enable = 1'b1; p = cyc;
    wait_until(p + 58);
    play_enable = 1'b0;
    check("t3 accepts", acc_q.size(), 3);
    if (acc_q.size() >= 3) begin
      check("t3 addr0", acc_q[0], 4);
      check("t3 addr1", acc_q[1], 5);
      check("t3 addr2", acc_q[2], 4);
      check("t3 len0", len_q[0], 4);
      check("t3 len2", len_q[2], 4);
    end
    check("t3 addr stable", addr_moved, 0);
    check("t3 pulses", pulse_q.size(), 5);

    // Slow slave: tick during WAIT raises sticky overrun
    do_reset();
    ws_cfg = 0; lat_cfg = 12; word_cfg = 32'h2468_1357;
    play_enable = 1'b1; p = cyc;
    wait_until(p + 15);
    check("t4 overrun early", sample_overrun, 0);
    wait_until(p + 21);
    check("t4 overrun set", sample_overrun, 1);
    wait_until(p + 35);
    play_enable = 1'b0;
    check("t4 pulses", pulse_q.size(), 2);
    if (pulse_q.size() >= 2) begin
      check("t4 lo cycle", pulse_q[0].cyc, p + 25);
      check("t4 lo data", pulse_q[0].data, 8'h13);
      check("t4 hi cycle", pulse_q[1].cyc, p + 30);
      check("t4 hi data", pulse_q[1].data, 8'h24);
    end
    wait_until(p + 45);
    check("t4 overrun sticky", sample_overrun, 1);

    // Pause mid-WAIT: word buffered, output resumes a full period after re-enable
    do_reset();
    ws_cfg = 0; lat_cfg = 8; word_cfg = 32'h9ABC_DEF0;
    play_enable = 1'b1; p = cyc;
    wait_until(p + 15);
    play_enable = 1'b0;
    wait_until(p + 40);
    check("t5 no pulse paused", pulse_q.size(), 0);
    play_enable = 1'b1; q = cyc;
    wait_until(q + 25);
    play_enable = 1'b0;
    check("t5 pulses", pulse_q.size(), 2);
    if (pulse_q.size() >= 2) begin
      check("t5 lo cycle", pulse_q[0].cyc, q + 10);
      check("t5 hi cycle", pulse_q[1].cyc, q + 20);
`ifdef FLASH_SAMPLE_ABS_EN
      check("t5 lo data", pulse_q[0].data, 8'h21);
      check("t5 hi data", pulse_q[1].data, 8'h65);
`else
      check("t5 lo data", pulse_q[0].data, 8'hDE);
      check("t5 hi data", pulse_q[1].data, 8'h9A);
`endif
    end
    check("t5 overrun", sample_overrun, 0);

    // Reset mid-WAIT: late readdatavalid ignored, next fetch restarts at 4
    do_reset();
    ws_cfg = 0; lat_cfg = 5; word_cfg = 32'h7777_7777;
    play_enable = 1'b1; p = cyc;
    wait_until(p + 13);
    reset_n = 1'b0; play_enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    wait_until(p + 30);
    check("t6 no pulse", pulse_q.size(), 0);
    check("t6 read idle", flash_read, 0);
    check("t6 input_data", input_data, 0);
    check("t6 overrun", sample_overrun, 0);
    word_cfg = 32'h0000_4321; lat_cfg = 0;
    play_enable = 1'b1; q = cyc;
    wait_until(q + 15);
    play_enable = 1'b0;
    check("t6 refetch pulses", pulse_q.size(), 1);
    if (pulse_q.size() >= 1) check("t6 refetch data", pulse_q[0].data, 8'h43);
    if (acc_q.size() >= 1) check("t6 refetch addr", acc_q[acc_q.size() - 1], 4);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
